// File: rtl/key_debounce_array_pkg.sv
// Shared constants and helpers for the key debounce array.
// Holds the default 20 ms stable window and the counter-width function.
package key_debounce_array_pkg;

    localparam int DEBOUNCE_STABLE_20MS_50M = 1000000;

    // Bits needed to hold the values 0 .. value-1.
    function automatic int clog2(input int value);
        int width;
        int rem;
        width = 0;
        rem   = value - 1;
        while (rem > 0) begin
            width = width + 1;
            rem   = rem >> 1;
        end
        return width;
    endfunction

endpackage

// File: rtl/key_debounce_array_debounce_channel.sv
// One key channel: pin synchroniser, stability counter and registered press/release pulses.
// out_key is always active-high (1 = pressed) whatever the pin polarity.
module debounce_channel
    import key_debounce_array_pkg::*;
#(
    parameter int STABLE_CYCLES = DEBOUNCE_STABLE_20MS_50M,
    parameter int SYNC_STAGES   = 2,
    parameter int ACTIVE_LOW    = 1
) (
    input  logic clk,
    input  logic clr,
    input  logic in_key,
    output logic out_key,
    output logic press,
    output logic release_pulse
);

    localparam int                CNT_W    = clog2(STABLE_CYCLES);
    localparam logic              IDLE_PIN = (ACTIVE_LOW != 0);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic [CNT_W-1:0]       cnt_q;
    logic                   sample;

    // The chain resets to the idle pin level so a key held through reset
    // is seen as a fresh press afterwards, never as a release.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            sync_q <= {SYNC_STAGES{IDLE_PIN}};
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], in_key};
        end
    end

    assign sample = sync_q[SYNC_STAGES-1] ^ IDLE_PIN;

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            cnt_q         <= '0;
            out_key       <= 1'b0;
            press         <= 1'b0;
            release_pulse <= 1'b0;
        end else begin
            press         <= 1'b0;
            release_pulse <= 1'b0;
            if (sample == out_key) begin
                cnt_q <= '0;
            end else if (cnt_q == CNT_LAST) begin
                // STABLE_CYCLES-th consecutive differing edge: accept the new level.
                cnt_q         <= '0;
                out_key       <= sample;
                press         <= sample;
                release_pulse <= ~sample;
            end else begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/key_debounce_array.sv
// Array of N_KEYS independent debounced key channels.
// The release output is named release_pulse because "release" is a reserved word.
module key_debounce_array
    import key_debounce_array_pkg::*;
#(
    parameter int N_KEYS        = 4,
    parameter int STABLE_CYCLES = DEBOUNCE_STABLE_20MS_50M,
    parameter int SYNC_STAGES   = 2,
    parameter int ACTIVE_LOW    = 1
) (
    input  logic              clk,
    input  logic              clr,
    input  logic [N_KEYS-1:0] in_key,
    output logic [N_KEYS-1:0] out_key,
    output logic [N_KEYS-1:0] press,
    output logic [N_KEYS-1:0] release_pulse
);

    for (genvar i = 0; i < N_KEYS; i++) begin : g_chan
        debounce_channel #(
            .STABLE_CYCLES (STABLE_CYCLES),
            .SYNC_STAGES   (SYNC_STAGES),
            .ACTIVE_LOW    (ACTIVE_LOW)
        ) u_chan (
            .clk           (clk),
            .clr           (clr),
            .in_key        (in_key[i]),
            .out_key       (out_key[i]),
            .press         (press[i]),
            .release_pulse (release_pulse[i])
        );
    end

endmodule

// File: doc/key_debounce_array.md
KEY_DEBOUNCE_ARRAY -- requirements
Module: key_debounce_array

Interface
REQ-001 Parameter N_KEYS, default 4: number of independent key channels, legal range 1..32.
REQ-002 Parameter STABLE_CYCLES, default 1000000: consecutive stable clk cycles required to accept a level change (20 ms at 50 MHz), legal range 2..2^24.
REQ-003 Parameter SYNC_STAGES, default 2: synchroniser flops per channel, legal range 2..4.
REQ-004 Parameter ACTIVE_LOW, default 1: 1 means a pressed key drives in_key low, 0 means pressed drives it high.
REQ-005 Port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-006 Port clr, input, 1 bit: asynchronous, active-high reset.
REQ-007 Port in_key, input, N_KEYS bits: raw asynchronous key pins, one bit per channel.
REQ-008 Port out_key, output, N_KEYS bits: debounced level per channel, 1 = pressed, regardless of ACTIVE_LOW.
REQ-009 Port press, output, N_KEYS bits: one-cycle pulse on the cycle out_key bit goes 0->1.
REQ-010 Port release, output, N_KEYS bits: one-cycle pulse on the cycle out_key bit goes 1->0.

Function
REQ-011 Each channel SHALL pass its in_key bit through SYNC_STAGES flops, then invert it when ACTIVE_LOW=1, giving the normalised sample s (1 = pressed).
REQ-012 Each channel SHALL hold a counter of width clog2(STABLE_CYCLES) bits that clears on every cycle where s equals out_key.
REQ-013 On a cycle where s differs from out_key and the counter is below STABLE_CYCLES-1, the counter SHALL increment by 1.
REQ-014 On a cycle where s differs from out_key and the counter equals STABLE_CYCLES-1, the channel SHALL set out_key to s, clear the counter, and pulse press (if s=1) or release (if s=0) on the same edge.
REQ-015 Latency SHALL be exactly STABLE_CYCLES clk edges from the first edge at which s differs from out_key to the edge at which out_key changes. The total pin-to-output delay is SYNC_STAGES+STABLE_CYCLES edges, +1 for asynchronous sampling.
REQ-016 A glitch on s shorter than STABLE_CYCLES cycles SHALL clear the counter and leave out_key, press and release unchanged.
REQ-017 The counter SHALL never wrap; it saturates at STABLE_CYCLES-1 only within the transition cycle.
REQ-018 press and release SHALL be registered, SHALL never both be 1 in the same channel, and SHALL each be high for exactly one cycle per accepted transition.
REQ-019 Channels SHALL be fully independent, so simultaneous transitions on any subset of keys are each reported in their own bit on the same cycle.
REQ-020 A key held indefinitely SHALL produce exactly one press pulse and no repeats.

Reset
REQ-021 While clr=1, all outputs SHALL be 0: out_key, press and release.
REQ-022 While clr=1, all counters SHALL be 0.
REQ-023 While clr=1, synchroniser flops SHALL load the inactive pin level (1 if ACTIVE_LOW=1, else 0), so a key held through reset is reported by one press pulse no earlier than SYNC_STAGES+STABLE_CYCLES cycles after clr deasserts, and release of clr never produces a spurious release pulse.
REQ-024 Asserting clr mid-count SHALL abandon the pending transition with no pulse.

Structure
REQ-025 A shared package/header SHALL hold the clog2 function and the default constant DEBOUNCE_STABLE_20MS_50M = 1000000.
REQ-026 A single sub-module, debounce_channel (synchroniser, counter, edge pulse), SHALL be instantiated N_KEYS times by a generate loop. The top level contains no other logic.

Verification (bench parameters: N_KEYS=4, STABLE_CYCLES=4, SYNC_STAGES=2, ACTIVE_LOW=1)
REQ-027 Hold clr=1 with in_key=4'b0000 (all pressed), then release clr -> outputs stay 0 for 6 cycles, then out_key=4'b1111 with press=4'b1111 for exactly one cycle and release=0 throughout.
REQ-028 Drive in_key[0] low at edge T and hold -> out_key[0]=1 and press[0]=1 at edge T+6; press[0]=0 at T+7; other channels unchanged.
REQ-029 With key 0 pressed, bounce in_key[0] high for 3 cycles then low -> no release pulse and out_key[0] stays 1; hold high for 4 cycles -> release[0]=1 for one cycle and out_key[0]=0.
REQ-030 Press keys 1 and 3 on the same edge -> press=4'b1010 for one cycle and out_key=4'b1010.
REQ-031 Assert clr two cycles into a pending press on key 2 -> out_key[2]=0 and press=0 immediately; after clr deasserts with the key still held, exactly one press[2] pulse arrives 6 cycles later.
REQ-032 Rerun REQ-028 with ACTIVE_LOW=0 and in_key driven high -> identical output timing.
